// File: rtl/present_key_schedule_pkg.sv
// Shared types and constants for the PRESENT round-key generator.
package present_key_schedule_pkg;

    // Controller states: waiting for a key, or streaming round keys.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of round keys emitted per loaded user key.
    localparam int ROUND_KEYS = 32;
    // Width of each emitted round key.
    localparam int RK_WIDTH   = 64;
    // Left-rotation distance applied to the key register on every update.
    localparam int ROT_AMT    = 61;

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit substitution box, purely combinational.
module present_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Fixed PRESENT S-box lookup.
    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'h5;
            4'h2: dout = 4'h6;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;
            4'h5: dout = 4'h0;
            4'h6: dout = 4'hA;
            4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;
            4'h9: dout = 4'hE;
            4'hA: dout = 4'hF;
            4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;
            4'hD: dout = 4'h7;
            4'hE: dout = 4'h1;
            4'hF: dout = 4'h2;
            default: dout = 4'h0;
        endcase
    end

endmodule

// File: rtl/present_key_schedule.sv
// PRESENT key schedule: loads an 80- or 128-bit user key on start and
// streams the 32 round keys K1..K32 over a valid/ready interface.
module present_key_schedule
    import present_key_schedule_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [RK_WIDTH-1:0]  rk_data,
    output logic [4:0]           rk_idx,
    output logic                 rk_last
);

    localparam logic [4:0] LAST_IDX = 5'(ROUND_KEYS - 1);

    state_t               state_reg, state_next;
    logic [KEY_WIDTH-1:0] key_reg, key_next;
    logic [KEY_WIDTH-1:0] rot_key, upd_key;
    logic [4:0]           idx_reg, idx_next;
    logic [4:0]           rcon;
    logic                 handshake;

    // Valid is a pure function of state so it never waits on rk_ready.
    assign rk_valid  = (state_reg == RUN);
    assign busy      = rk_valid;
    assign rk_last   = rk_valid && (idx_reg == LAST_IDX);
    assign rk_data   = key_reg[KEY_WIDTH-1 -: RK_WIDTH];
    assign rk_idx    = idx_reg;
    assign handshake = rk_valid && rk_ready;

    // Round counter mixed into the key is the index of the key being produced next.
    assign rcon    = idx_reg + 5'd1;
    assign rot_key = (key_reg << ROT_AMT) | (key_reg >> (KEY_WIDTH - ROT_AMT));

    generate
        if (KEY_WIDTH == 80) begin : g_k80
            logic [3:0] sb_out;
            present_sbox u_sbox (
                .din  (rot_key[79:76]),
                .dout (sb_out)
            );
            assign upd_key = {sb_out, rot_key[75:20], rot_key[19:15] ^ rcon, rot_key[14:0]};
        end else if (KEY_WIDTH == 128) begin : g_k128
            logic [7:0] sb_out;
            for (genvar gi = 0; gi < 2; gi++) begin : g_sbox
                present_sbox u_sbox (
                    .din  (rot_key[127-4*gi -: 4]),
                    .dout (sb_out[7-4*gi -: 4])
                );
            end
            assign upd_key = {sb_out, rot_key[119:67], rot_key[66:62] ^ rcon, rot_key[61:0]};
        end else begin : g_bad_width
            $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
        end
    endgenerate

    // Next-state logic: load on start in IDLE, advance one key per handshake in RUN.
    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_next   = key_in;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (rk_last) begin
                        // Final key consumed: stop without touching key or index.
                        state_next = IDLE;
                    end else begin
                        key_next = upd_key;
                        idx_next = rcon;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, key and index registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            idx_reg   <= idx_next;
        end
    end

endmodule

// File: tb/tb_present_key_schedule.sv
// Scoreboard bench: drives 80- and 128-bit instances with shared stimulus and
// checks every handshaken round key against a software key-schedule model.
module tb_present_key_schedule;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [127:0] key_bus = '0;

    logic        busy80, valid80, last80;
    logic [63:0] data80;
    logic [4:0]  idx80;
    logic        busy128, valid128, last128;
    logic [63:0] data128;
    logic [4:0]  idx128;

    exp_t q80[$];
    exp_t q128[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vcnt80  = 0;
    bit   stalled[2];
    logic [69:0] stall_val[2];

    always #5 clk = ~clk;

    present_key_schedule #(.KEY_WIDTH(80)) dut80 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_bus[79:0]),
        .busy(busy80), .rk_valid(valid80), .rk_ready(rk_ready),
        .rk_data(data80), .rk_idx(idx80), .rk_last(last80)
    );

    present_key_schedule #(.KEY_WIDTH(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_bus),
        .busy(busy128), .rk_valid(valid128), .rk_ready(rk_ready),
        .rk_data(data128), .rk_idx(idx128), .rk_last(last128)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [3:0] t [16];
        t = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        return t[x];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference schedule: 32 keys per user key, top 64 bits of the register each round.
    task automatic push_expected(input logic [127:0] k);
        logic [79:0]  a;
        logic [127:0] b;
        a = k[79:0];
        b = k;
        for (int i = 1; i <= 32; i++) begin
            q80.push_back('{data: a[79:16], idx: 5'(i - 1), last: (i == 32)});
            q128.push_back('{data: b[127:64], idx: 5'(i - 1), last: (i == 32)});
            if (i < 32) begin
                a = (a << 61) | (a >> 19);
                a[79:76] = sb(a[79:76]);
                a[19:15] = a[19:15] ^ 5'(i);
                b = (b << 61) | (b >> 67);
                b[127:124] = sb(b[127:124]);
                b[123:120] = sb(b[123:120]);
                b[66:62] = b[66:62] ^ 5'(i);
            end
        end
    endtask

    task automatic mon(input int w, input logic v, input logic [63:0] d,
                       input logic [4:0] i, input logic l);
        exp_t e;
        bit   empty;
        if (v && stalled[w])
            chk(w == 0 ? "stall_hold80" : "stall_hold128", {d, i, l}, stall_val[w]);
        if (v && rk_ready) begin
            empty = (w == 0) ? (q80.size() == 0) : (q128.size() == 0);
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_key w%0d: got idx %0d data %h, expected none", w, i, d);
            end else begin
                e = (w == 0) ? q80.pop_front() : q128.pop_front();
                $display("[TB] w%0d idx=%0d data=%h last=%0b exp=%h", w == 0 ? 80 : 128, i, d, l, e.data);
                chk(w == 0 ? "rk_data80" : "rk_data128", d, e.data);
                chk(w == 0 ? "rk_idx80" : "rk_idx128", i, e.idx);
                chk(w == 0 ? "rk_last80" : "rk_last128", l, e.last);
            end
        end
        stalled[w]   = v && !rk_ready;
        stall_val[w] = {d, i, l};
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid80) vcnt80++;
            mon(0, valid80, data80, idx80, last80);
            mon(1, valid128, data128, idx128, last128);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_out80"}, {busy80, valid80, last80, idx80, data80}, '0);
        chk({tag, "_out128"}, {busy128, valid128, last128, idx128, data128}, '0);
    endtask

    // Issue a start while idle; K1 must be on the outputs one cycle later.
    task automatic do_start(input logic [127:0] k);
        start   = 1'b1;
        key_bus = k;
        push_expected(k);
        vcnt80 = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("k1_latency80", {busy80, valid80, idx80}, {1'b1, 1'b1, 5'd0});
        chk("k1_latency128", {busy128, valid128, idx128}, {1'b1, 1'b1, 5'd0});
    endtask

    task automatic run_seq(input bit rnd, input int start_at, input int rst_at,
                           input bit start_last, output bit completed);
        bit injected;
        int cyc;
        injected  = 0;
        cyc       = 0;
        completed = 0;
        forever begin
            start = 1'b0;
            if (!busy80) begin
                completed = 1;
                break;
            end
            if (cyc >= 600) begin
                n_tests++;
                n_fail++;
                $display("FAIL seq_timeout: got busy after %0d cycles, expected done", cyc);
                break;
            end
            if (rst_at >= 0 && int'(idx80) == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_reset");
                q80.delete();
                q128.delete();
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("idle_after_reset", {busy80, busy128}, 2'b00);
                break;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start_at >= 0 && !injected && int'(idx80) == start_at) begin
                start    = 1'b1;
                key_bus  = rand128();
                injected = 1;
            end
            if (start_last && last80) begin
                rk_ready = 1'b1;
                start    = 1'b1;
                key_bus  = rand128();
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic end_checks();
        chk("end_state80", {busy80, valid80, last80, idx80}, {1'b0, 1'b0, 1'b0, 5'd31});
        chk("end_state128", {busy128, valid128, last128, idx128}, {1'b0, 1'b0, 1'b0, 5'd31});
        chk("queue_drained", q80.size() + q128.size(), 0);
    endtask

    initial begin
        bit ok;
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_release", {busy80, busy128}, 2'b00);

        // All-zero key, consumer always ready: known K1/K2 and exactly 32 valid cycles.
        rk_ready = 1'b1;
        do_start('0);
        chk("zero_k1_80", data80, 64'h0);
        chk("zero_k1_128", data128, 64'h0);
        @(posedge clk);
        #1;
        chk("zero_k2_80", data80, 64'hC000000000000000);
        chk("zero_k2_128", data128, 64'hCC00000000000000);
        run_seq(0, -1, -1, 0, ok);
        if (ok) end_checks();
        chk("valid_cycles80", vcnt80, 32);

        // All-ones key with random back-pressure.
        do_start('1);
        run_seq(1, -1, -1, 0, ok);
        if (ok) end_checks();

        // A start in the middle of generation must be ignored.
        do_start(rand128());
        run_seq(1, 10, -1, 0, ok);
        if (ok) end_checks();

        // Reset mid-generation, then a fresh start.
        do_start(rand128());
        run_seq(1, -1, 17, 0, ok);
        do_start(rand128());
        run_seq(1, -1, -1, 0, ok);
        if (ok) end_checks();

        // Start coinciding with the final handshake is ignored.
        do_start(rand128());
        run_seq(0, -1, -1, 1, ok);
        if (ok) end_checks();
        repeat (3) @(posedge clk);
        #1;
        chk("no_reload", {busy80, valid80, busy128, valid128}, 4'b0000);
        do_start(rand128());
        run_seq(1, -1, -1, 0, ok);
        if (ok) end_checks();

        // A few more random keys under random back-pressure.
        for (int n = 0; n < 3; n++) begin
            do_start(rand128());
            run_seq(1, -1, -1, 0, ok);
            if (ok) end_checks();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/present_key_schedule.md
PRESENT_KEY_SCHEDULE -- requirements
Module: present_key_schedule

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 80, user key length in bits; legal values are 80 and 128 only.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have start  input  1  one-cycle request to load key_in and begin generation.
REQ-005 SHALL have key_in  input  KEY_WIDTH  user key, sampled only on an accepted start.
REQ-006 SHALL have busy  output  1  high from accepted start until the last round key is accepted.
REQ-007 SHALL have rk_valid  output  1  round key on rk_data is valid.
REQ-008 SHALL have rk_ready  input  1  consumer accepts the round key this cycle.
REQ-009 SHALL have rk_data  output  64  current round key K(i).
REQ-010 SHALL have rk_idx  output  5  zero-based round-key index i-1, range 0..31.
REQ-011 SHALL have rk_last  output  1  high with rk_valid when rk_idx equals 31.

Function
REQ-012 SHALL implement a two-state machine, IDLE and RUN; reset enters IDLE.
REQ-013 In IDLE, start SHALL load key_in into the key register, clear rk_idx to 0, and enter RUN on the next edge.
REQ-014 In RUN, rk_valid SHALL be high; rk_data SHALL equal the key register bits [KEY_WIDTH-1 : KEY_WIDTH-64].
REQ-015 K1 SHALL appear on the first cycle after start, giving a latency of one cycle.
REQ-016 A handshake SHALL occur on any cycle where rk_valid and rk_ready are both high; exactly one key update SHALL occur per handshake.
REQ-017 For KEY_WIDTH=80, each update SHALL do the following, in order:
- rotate the register left by 61 bits;
- replace bits [79:76] with their PRESENT S-box substitution;
- XOR bits [19:15] with rk_idx+1.
REQ-018 For KEY_WIDTH=128, each update SHALL do the following, in order:
- rotate the register left by 61 bits;
- replace bits [127:124] and bits [123:120] with their S-box substitutions;
- XOR bits [66:62] with rk_idx+1.
REQ-019 The round counter XORed in SHALL be 5 bits, values 1..31; rk_idx SHALL increment by 1 per handshake.
REQ-020 While rk_valid is high and rk_ready is low, rk_data, rk_idx and rk_last SHALL remain stable.
REQ-021 A handshake with rk_last high SHALL return the block to IDLE on the next edge without a key update.
- busy and rk_valid SHALL fall on that same edge.
- rk_idx SHALL hold 31 until the next start.
REQ-022 start SHALL be ignored while busy is high; it SHALL not reload or restart generation.
REQ-023 start and the final handshake in the same cycle: the final handshake completes; start is ignored.
REQ-024 rk_valid SHALL not depend combinationally on rk_ready.
REQ-025 32 round keys K1..K32 SHALL be produced per start.

Reset
REQ-026 rst_n low SHALL immediately force all of the following, regardless of clk:
- state IDLE;
- busy=0, rk_valid=0, rk_last=0;
- rk_idx=0, rk_data=0, key register=0.
REQ-027 Reset asserted mid-generation SHALL abandon the sequence; the first generation after release SHALL require a new start.
REQ-028 Deassertion SHALL need no other stimulus; the first active edge after release SHALL behave as IDLE.

Structure
REQ-029 A shared package SHALL hold the following:
- the state enum;
- the constants ROUND_KEYS=32, RK_WIDTH=64, ROT_AMT=61.
REQ-030 Substitution SHALL instantiate the existing present_sbox sub-module:
- one instance for KEY_WIDTH=80;
- two instances for KEY_WIDTH=128, chosen by a generate on KEY_WIDTH.
REQ-031 An illegal KEY_WIDTH SHALL fail elaboration.

Verification
REQ-032 KEY_WIDTH=80, key_in all zero, rk_ready tied high -> rk_data K1=0x0000000000000000 and K2=0xC000000000000000; rk_idx steps 0..31; exactly 32 valid cycles.
REQ-033 KEY_WIDTH=128, key_in all zero, rk_ready high -> K1=0x0000000000000000, K2=0xCC00000000000000; rk_last only at rk_idx=31.
REQ-034 KEY_WIDTH=80, key_in=0xFFFFFFFFFFFFFFFFFFFF, random rk_ready -> all 32 keys match the software model, and outputs stay stable during stalls.
REQ-035 start pulsed at rk_idx=10 with a different key -> the sequence is unaffected and K11..K32 match the first key's model.
REQ-036 rst_n pulsed low at rk_idx=17 -> outputs zero immediately; a new start then yields K1 of the new key one cycle later.
REQ-037 start in the same cycle as the final handshake -> IDLE follows, no reload; a later start then begins normally.
